// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//
// Multi-channel edge detector for asynchronous inputs such as keys, sensor
// strobes and external triggers. Every channel is fully independent and has:
//   - a SYNC_STAGES-deep synchroniser,
//   - a glitch filter that only changes the filtered level after the
//     synchronised input has disagreed with it for FILT_LEN consecutive
//     cycles,
//   - an edge-mode select (off / rise / fall / both),
//   - a registered one-cycle event pulse,
//   - a sticky event flag with synchronous per-channel clear.
// irq is the OR of all sticky flags.
//
// Optional feature, compile-time macro EDGE_DET_CNT_EN:
//   defined   -> per-channel CNT_W-bit saturating event counter on evt_cnt,
//                zeroed by clr (clr together with a pulse leaves it at 1).
//   undefined -> no counter flops, evt_cnt is tied to zero.
//
// Parameters
//   CH          number of channels (>= 1)
//   SYNC_STAGES synchroniser flops per channel (>= 2)
//   FILT_LEN    stable cycles required before the level changes (>= 1)
//   CNT_W       width of each event counter
//
// Ports
//   clk      in   1         system clock, rising edge
//   rst_n    in   1         asynchronous reset, active-low
//   din      in   CH        raw asynchronous inputs
//   mode     in   2*CH      per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr      in   CH        synchronous clear of sticky flag (and counter)
//   level    out  CH        filtered, synchronised level
//   pulse    out  CH        one-cycle event pulse
//   sticky   out  CH        latched event flag
//   irq      out  1         OR of all sticky bits
//   evt_cnt  out  CH*CNT_W  event counters, channel i at [i*CNT_W +: CNT_W]
//
// Latency: a stable din transition shows up on level/pulse on clock edge
// SYNC_STAGES+FILT_LEN after the first edge that samples it. sticky and the
// counter follow one edge after the pulse.
// -----------------------------------------------------------------------------
module multi_edge_detect #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         din,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH-1:0]         clr,
    output logic [CH-1:0]         level,
    output logic [CH-1:0]         pulse,
    output logic [CH-1:0]         sticky,
    output logic                  irq,
    output logic [CH*CNT_W-1:0]   evt_cnt
);

    // Filter counter is wide enough to hold FILT_LEN-1 for any FILT_LEN >= 1.
    localparam int                FCNT_W   = $clog2(FILT_LEN) + 1;
    localparam logic [FCNT_W-1:0] FILT_MAX = FCNT_W'(FILT_LEN - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [FCNT_W-1:0]      fcnt_reg;
            logic                   level_reg;
            logic                   pulse_reg;
            logic                   sticky_reg;
            logic                   sync_out;
            logic [1:0]             ch_mode;
            logic                   update;
            logic                   pulse_next;

            assign sync_out = sync_reg[SYNC_STAGES-1];
            assign ch_mode  = mode[2*gi +: 2];

            // The level flips on this edge: the synchronised input has
            // disagreed with the level for FILT_LEN consecutive samples.
            assign update = (sync_out != level_reg) && (fcnt_reg == FILT_MAX);

            // mode bit 0 enables rising events, bit 1 enables falling events.
            // mode is looked at only on the update edge, so a mode change
            // never retroactively affects a transition already reported.
            assign pulse_next = update && ((sync_out && ch_mode[0]) ||
                                           (!sync_out && ch_mode[1]));

            // Synchroniser: shift din in from the low end.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], din[gi]};
                end
            end

            // Glitch filter: any sample agreeing with the current level
            // restarts the count, so only an unbroken run changes the level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fcnt_reg  <= '0;
                    level_reg <= 1'b0;
                end else if (sync_out == level_reg) begin
                    fcnt_reg  <= '0;
                end else if (update) begin
                    level_reg <= sync_out;
                    fcnt_reg  <= '0;
                end else begin
                    fcnt_reg  <= fcnt_reg + 1'b1;
                end
            end

            // Pulse is registered alongside the level. sticky is set from the
            // registered pulse, so a clr asserted during the pulse cycle sees
            // the pulse at the same edge and the event is kept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pulse_reg  <= 1'b0;
                    sticky_reg <= 1'b0;
                end else begin
                    pulse_reg  <= pulse_next;
                    sticky_reg <= (sticky_reg & ~clr[gi]) | pulse_reg;
                end
            end

            assign level[gi]  = level_reg;
            assign pulse[gi]  = pulse_reg;
            assign sticky[gi] = sticky_reg;

`ifdef EDGE_DET_CNT_EN
            logic [CNT_W-1:0] cnt_reg;

            // Saturating counter; clr wins over the increment but a pulse
            // arriving on the clear edge is still counted (result 1).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (clr[gi]) begin
                    cnt_reg <= pulse_reg ? CNT_W'(1) : '0;
                end else if (pulse_reg && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign evt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`else
            assign evt_cnt[gi*CNT_W +: CNT_W] = '0;
`endif
        end
    endgenerate

    // Driven only by flops, so the OR cannot glitch on its own.
    assign irq = |sticky;

endmodule

// File: tb/tb_multi_edge_detect.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detect
//
// Directed testbench for multi_edge_detect at default parameters
// (CH=4, SYNC_STAGES=2, FILT_LEN=4, CNT_W=8). Inputs are driven 1 time unit
// after a rising edge and outputs are sampled at the same point, so "step N"
// means N further rising edges have been seen. With these defaults a held din
// transition reaches level/pulse on the 6th edge after it is driven.
// Compile with +define+EDGE_DET_CNT_EN to exercise the event counters.
// -----------------------------------------------------------------------------
module tb_multi_edge_detect;

    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic                clk;
    logic                rst_n;
    logic [CH-1:0]       din;
    logic [2*CH-1:0]     mode;
    logic [CH-1:0]       clr;
    logic [CH-1:0]       level;
    logic [CH-1:0]       pulse;
    logic [CH-1:0]       sticky;
    logic                irq;
    logic [CH*CNT_W-1:0] evt_cnt;

    int checks = 0;
    int errors = 0;

    multi_edge_detect #(
        .CH(CH), .SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
        .level(level), .pulse(pulse), .sticky(sticky), .irq(irq),
        .evt_cnt(evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        clr = '1;
        step(1);
        clr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = '0; mode = '0; clr = '0;
        step(2);
        checks++;
        if ({level, pulse, sticky, irq} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {level, pulse, sticky, irq});
        end
        checks++;
        if (evt_cnt !== '0) begin
            errors++;
            $display("FAIL reset_evt_cnt: got %h expected 0", evt_cnt);
        end
        rst_n = 1'b1;
        step(1);
        $display("test_reset done");
    endtask

    // ch0 rise-only: pulse at edge 6, sticky one edge later, no fall pulse.
    task automatic test_rise();
        mode[1:0] = 2'b01;
        din[0] = 1'b1;
        step(5);
        checks++;
        if (level[0] !== 1'b0 || pulse[0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_early: got level=%b pulse=%b expected 0 0", level[0], pulse[0]);
        end
        step(1);
        checks++;
        if (level[0] !== 1'b1 || pulse[0] !== 1'b1 || sticky[0] !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rise_edge6: got l=%b p=%b s=%b irq=%b expected 1 1 0 0",
                     level[0], pulse[0], sticky[0], irq);
        end
        step(1);
        checks++;
        if (pulse[0] !== 1'b0 || sticky[0] !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL rise_after: got p=%b s=%b irq=%b expected 0 1 1", pulse[0], sticky[0], irq);
        end
        din[0] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            checks++;
            if (pulse[0] !== 1'b0 || level[0] !== (i < 6)) begin
                errors++;
                $display("FAIL rise_nofall step %0d: got l=%b p=%b expected l=%b p=0",
                         i, level[0], pulse[0], (i < 6));
            end
        end
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        checks++;
        if (sticky[0] !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rise_clr: got s=%b irq=%b expected 0 0", sticky[0], irq);
        end
        $display("test_rise done");
    endtask

    // ch1 both-edges: 3-cycle glitch is filtered, 4-cycle pulse gives rise+fall.
    task automatic test_glitch();
        mode[3:2] = 2'b11;
        din[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i == 3) din[1] = 1'b0;
            checks++;
            if (level[1] !== 1'b0 || pulse[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch3 step %0d: got l=%b p=%b expected 0 0", i, level[1], pulse[1]);
            end
        end
        din[1] = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step(1);
            if (i == 4) din[1] = 1'b0;
            checks++;
            if (pulse[1] !== (i == 6 || i == 10) || level[1] !== (i >= 6 && i < 10)) begin
                errors++;
                $display("FAIL glitch4 step %0d: got l=%b p=%b expected l=%b p=%b",
                         i, level[1], pulse[1], (i >= 6 && i < 10), (i == 6 || i == 10));
            end
        end
        clr[1] = 1'b1;
        step(1);
        clr[1] = 1'b0;
        $display("test_glitch done");
    endtask

    // ch2 fall-only: clr during the pulse cycle must not lose the event.
    task automatic test_clr_collision();
        mode[5:4] = 2'b10;
        din[2] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            checks++;
            if (pulse[2] !== 1'b0) begin
                errors++;
                $display("FAIL fall_norise step %0d: got p=%b expected 0", i, pulse[2]);
            end
        end
        din[2] = 1'b0;
        step(6);
        checks++;
        if (pulse[2] !== 1'b1 || level[2] !== 1'b0) begin
            errors++;
            $display("FAIL fall_pulse: got l=%b p=%b expected 0 1", level[2], pulse[2]);
        end
        clr[2] = 1'b1;
        step(1);
        clr[2] = 1'b0;
        checks++;
        if (sticky[2] !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL clr_same_cycle: got s=%b irq=%b expected 1 1", sticky[2], irq);
        end
        clr[2] = 1'b1;
        step(1);
        clr[2] = 1'b0;
        checks++;
        if (sticky[2] !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL clr_next_cycle: got s=%b irq=%b expected 0 0", sticky[2], irq);
        end
        $display("test_clr_collision done");
    endtask

    // ch3 rise-only: saturating counter (or tied-zero counter in the default build).
    task automatic test_counter();
        mode[7:6] = 2'b01;
`ifdef EDGE_DET_CNT_EN
        for (int e = 1; e <= 300; e++) begin
            din[3] = 1'b1;
            step(6);
            din[3] = 1'b0;
            step(6);
            if (e == 10 || e == 255 || e == 300) begin
                checks++;
                if (evt_cnt[3*CNT_W +: CNT_W] !== ((e > 255) ? 8'd255 : 8'(e))) begin
                    errors++;
                    $display("FAIL cnt_after_%0d: got %0d expected %0d",
                             e, evt_cnt[3*CNT_W +: CNT_W], (e > 255) ? 255 : e);
                end
            end
        end
        din[3] = 1'b1;
        step(6);
        clr[3] = 1'b1;
        step(1);
        clr[3] = 1'b0;
        checks++;
        if (evt_cnt[3*CNT_W +: CNT_W] !== 8'd1 || sticky[3] !== 1'b1) begin
            errors++;
            $display("FAIL cnt_clr_pulse: got cnt=%0d s=%b expected 1 1",
                     evt_cnt[3*CNT_W +: CNT_W], sticky[3]);
        end
        din[3] = 1'b0;
        step(6);
`else
        din[3] = 1'b1;
        step(6);
        din[3] = 1'b0;
        step(6);
        checks++;
        if (evt_cnt !== '0 || sticky[3] !== 1'b1) begin
            errors++;
            $display("FAIL cnt_disabled: got cnt=%h s=%b expected 0 1", evt_cnt, sticky[3]);
        end
`endif
        clear_all();
        $display("test_counter done");
    endtask

    // All channels both-edges together; then ch0 mode off still tracks level.
    task automatic test_simultaneous();
        mode = 8'hFF;
        din = 4'hF;
        step(5);
        checks++;
        if (pulse !== 4'h0 || level !== 4'h0) begin
            errors++;
            $display("FAIL simul_early: got l=%h p=%h expected 0 0", level, pulse);
        end
        step(1);
        checks++;
        if (pulse !== 4'hF || level !== 4'hF) begin
            errors++;
            $display("FAIL simul_rise: got l=%h p=%h expected f f", level, pulse);
        end
        step(1);
        checks++;
        if (pulse !== 4'h0 || sticky !== 4'hF || irq !== 1'b1) begin
            errors++;
            $display("FAIL simul_sticky: got p=%h s=%h irq=%b expected 0 f 1", pulse, sticky, irq);
        end
        clear_all();
        mode[1:0] = 2'b00;
        din = 4'h0;
        step(6);
        checks++;
        if (level !== 4'h0 || pulse !== 4'hE) begin
            errors++;
            $display("FAIL simul_mode_off: got l=%h p=%h expected 0 e", level, pulse);
        end
        step(1);
        clear_all();
        checks++;
        if (sticky !== 4'h0) begin
            errors++;
            $display("FAIL simul_clr: got s=%h expected 0", sticky);
        end
        $display("test_simultaneous done");
    endtask

    // Asynchronous reset mid-filter, then a full-latency rise after release.
    task automatic test_reset_midop();
        mode = 8'hFF;
        din[3] = 1'b1;
        step(7);
        checks++;
        if (sticky[3] !== 1'b1 || level[3] !== 1'b1) begin
            errors++;
            $display("FAIL midop_setup: got l=%b s=%b expected 1 1", level[3], sticky[3]);
        end
        din[0] = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({level, pulse, sticky, irq} !== 13'd0 || evt_cnt !== '0) begin
            errors++;
            $display("FAIL midop_async_reset: got %b cnt=%h expected 0",
                     {level, pulse, sticky, irq}, evt_cnt);
        end
        step(2);
        rst_n = 1'b1;
        step(5);
        checks++;
        if (level !== 4'h0 || pulse !== 4'h0) begin
            errors++;
            $display("FAIL midop_early: got l=%h p=%h expected 0 0", level, pulse);
        end
        step(1);
        checks++;
        if (level !== 4'h9 || pulse !== 4'h9) begin
            errors++;
            $display("FAIL midop_rise: got l=%h p=%h expected 9 9", level, pulse);
        end
        $display("test_reset_midop done");
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_clr_collision();
        test_counter();
        test_simultaneous();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
